// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the CPU memory responder.
// Holds the per-channel FSM state encoding and the latency counter sizing.
// Imported by resp_channel and cpu_mem_responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_t;

  // Legal latency range for either channel; the counter below is sized for LAT_MAX.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/resp_channel.sv
// One response channel: accepts a request, holds the array word, returns it after LAT cycles.
// Latency: valid rises LAT cycles after the accept cycle (LAT=1 -> the very next cycle).
// Backpressure: valid and data are held stable in RESP until rsp_rdy; one outstanding request.
module resp_channel
  import mem_resp_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [31:0] rd_dat,
  input  logic        rsp_rdy,
  output logic        idle,
  output logic        rsp_vld,
  output logic [31:0] rsp_dat
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT - 1);

  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hold;

  // State and latency counter registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Holding register captures the array word on the accept edge and drives the data output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold <= '0;
    end else if (accept) begin
      hold <= rd_dat;
    end
  end

  // Next-state logic: a count of 1 in WAIT means the next cycle is the response cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign idle    = (state == IDLE);
  assign rsp_vld = (state == RESP);
  assign rsp_dat = hold;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU fetch and load/store channels over one single-port word array.
// Latency: fetch INST_LAT, load DATA_LAT cycles after accept; stores complete in the accept cycle.
// Backpressure: one outstanding request per channel; data wins fetch conflicts. MEM_RESP_PERF_EN adds stall counters.
module cpu_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int INST_LAT   = 1,
  parameter int DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
`ifdef MEM_RESP_PERF_EN
  ,
  output logic [31:0] perf_inst_stall,
  output logic [31:0] perf_data_stall
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  data_req;
  logic                  inst_idle;
  logic                  data_idle;
  logic                  inst_acc;
  logic                  load_acc;
  logic                  store_acc;
  logic [ADDR_WIDTH-1:0] port_idx;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  // Byte offset and bits above the array index are ignored, so addresses alias.
  assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Any data request (read or write) blocks the fetch port that cycle.
  assign data_req       = MemRead | MemWrite;
  assign Mem_Req_Ready  = rst & data_idle;
  assign Inst_Req_Ready = rst & inst_idle & ~data_req;

  assign inst_acc  = Inst_Req_Valid & Inst_Req_Ready;
  assign store_acc = MemWrite & Mem_Req_Ready;
  assign load_acc  = MemRead & ~MemWrite & Mem_Req_Ready;

  // Only one access is accepted per cycle, so a single address port serves both channels.
  assign port_idx = data_req ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
  assign rd_word  = mem[port_idx];

  // Byte-strobed store on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem[port_idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  resp_channel #(.LAT(INST_LAT)) u_inst_chan (
    .clk     (clk),
    .rst     (rst),
    .accept  (inst_acc),
    .rd_dat  (rd_word),
    .rsp_rdy (Inst_Ready),
    .idle    (inst_idle),
    .rsp_vld (Inst_Valid),
    .rsp_dat (Instruction)
  );

  resp_channel #(.LAT(DATA_LAT)) u_data_chan (
    .clk     (clk),
    .rst     (rst),
    .accept  (load_acc),
    .rd_dat  (rd_word),
    .rsp_rdy (Read_data_Ready),
    .idle    (data_idle),
    .rsp_vld (Read_data_Valid),
    .rsp_dat (Read_data)
  );

`ifdef MEM_RESP_PERF_EN
  // Stall counters: cycles where a request is presented but not accepted; wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_inst_stall <= '0;
      perf_data_stall <= '0;
    end else begin
      if (Inst_Req_Valid && !Inst_Req_Ready) begin
        perf_inst_stall <= perf_inst_stall + 32'd1;
      end
      if (data_req && !Mem_Req_Ready) begin
        perf_data_stall <= perf_data_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  localparam int INST_LAT = 1;
  localparam int DATA_LAT = 2;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic        Inst_Req_Valid = 1'b0;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b1;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b1;
`ifdef MEM_RESP_PERF_EN
  logic [31:0] perf_inst_stall;
  logic [31:0] perf_data_stall;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t iq[$];
  exp_t dq[$];

  cpu_mem_responder #(.ADDR_WIDTH(12), .INST_LAT(INST_LAT), .DATA_LAT(DATA_LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Inst_Req_Valid  (Inst_Req_Valid),
    .Inst_Req_Ready  (Inst_Req_Ready),
    .Instruction     (Instruction),
    .Inst_Valid      (Inst_Valid),
    .Inst_Ready      (Inst_Ready),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready)
`ifdef MEM_RESP_PERF_EN
    ,
    .perf_inst_stall (perf_inst_stall),
    .perf_data_stall (perf_data_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations on each response handshake, checks data and rise cycle.
  int  i_rise = 0;
  int  d_rise = 0;
  bit  iv_prev = 1'b0;
  bit  dv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (Inst_Valid && !iv_prev) i_rise = cyc;
    if (Read_data_Valid && !dv_prev) d_rise = cyc;
    if (Inst_Valid && Inst_Ready) begin
      if (iq.size() == 0) begin
        total++; bad++;
        $display("FAIL inst_unexpected actual=0x%08h required=no response", Instruction);
      end else begin
        e = iq.pop_front();
        chk("inst_data", Instruction, e.dat);
        chk("inst_latency", i_rise, e.due);
      end
    end
    if (Read_data_Valid && Read_data_Ready) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $display("FAIL data_unexpected actual=0x%08h required=no response", Read_data);
      end else begin
        e = dq.pop_front();
        chk("load_data", Read_data, e.dat);
        chk("load_latency", d_rise, e.due);
      end
    end
    iv_prev = Inst_Valid;
    dv_prev = Read_data_Valid;
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (Mem_Req_Ready) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL store_accept actual=timeout required=accept addr=0x%08h", a);
    end
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] e, input bit push);
    exp_t x;
    bit got = 1'b0;
    Address = a; MemRead = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (Mem_Req_Ready) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL load_accept actual=timeout required=accept addr=0x%08h", a);
    end else if (push) begin
      x.dat = e; x.due = cyc + DATA_LAT; dq.push_back(x);
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc_v, input logic [31:0] e);
    exp_t x;
    bit got = 1'b0;
    PC = pc_v; Inst_Req_Valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (Inst_Req_Ready) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL fetch_accept actual=timeout required=accept pc=0x%08h", pc_v);
    end else begin
      x.dat = e; x.due = cyc + INST_LAT; iq.push_back(x);
    end
    @(posedge clk); #1;
    Inst_Req_Valid = 1'b0;
  endtask

  initial begin
    exp_t x;
    bit   seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_req_ready", Inst_Req_Ready, 0);
    chk("rst_mem_req_ready", Mem_Req_Ready, 0);
    chk("rst_inst_valid", Inst_Valid, 0);
    chk("rst_read_valid", Read_data_Valid, 0);
    chk("rst_instruction", Instruction, 0);
    chk("rst_read_data", Read_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_inst_req_ready", Inst_Req_Ready, 1);
    chk("idle_mem_req_ready", Mem_Req_Ready, 1);
    @(posedge clk); #1;

    // Preload word 0x10 through the store port; ready returns the next cycle
    do_store(32'h0000_0040, 32'h0050_0093, 4'hF);
    @(negedge clk);
    chk("store_ready_next", Mem_Req_Ready, 1);
    @(posedge clk); #1;

    // Fetch with INST_LAT=1, plus aliased addresses hitting the same word
    do_fetch(32'h0000_0040, 32'h0050_0093);
    idle_cycles(2);
    do_fetch(32'h0000_4043, 32'h0050_0093);
    idle_cycles(2);

    // Byte-strobed store then read-after-write load
    do_store(32'h0000_0100, 32'h1122_3344, 4'hF);
    do_store(32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
    do_load(32'h0000_0100, 32'h11BB_33DD, 1'b1);
    idle_cycles(4);

    // Same-cycle fetch and load: data wins, fetch goes next cycle
    PC = 32'h0000_0040; Inst_Req_Valid = 1'b1;
    Address = 32'h0000_0100; MemRead = 1'b1;
    @(negedge clk);
    chk("conflict_mem_ready", Mem_Req_Ready, 1);
    chk("conflict_inst_ready", Inst_Req_Ready, 0);
    x.dat = 32'h11BB_33DD; x.due = cyc + DATA_LAT; dq.push_back(x);
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    chk("conflict_inst_next", Inst_Req_Ready, 1);
    x.dat = 32'h0050_0093; x.due = cyc + INST_LAT; iq.push_back(x);
    @(posedge clk); #1;
    Inst_Req_Valid = 1'b0;
    idle_cycles(4);

    // Response held off for 5 cycles; a second load must wait
    Read_data_Ready = 1'b0;
    do_load(32'h0000_0040, 32'h0050_0093, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Read_data_Valid) seen = 1'b1;
    end
    chk("hold_valid_seen", seen, 1);
    @(posedge clk); #1;
    Address = 32'h0000_0100; MemRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", Read_data_Valid, 1);
      chk("hold_data", Read_data, 32'h0050_0093);
      chk("hold_mem_ready", Mem_Req_Ready, 0);
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    Read_data_Ready = 1'b1;
    do_load(32'h0000_0100, 32'h11BB_33DD, 1'b1);
    idle_cycles(4);

    // Reset during data WAIT drops the response but keeps the array
    do_load(32'h0000_0100, 32'h0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_inst_ready", Inst_Req_Ready, 1);
    chk("post_rst_mem_ready", Mem_Req_Ready, 1);
    chk("post_rst_read_data", Read_data, 0);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_valid", Read_data_Valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    do_load(32'h0000_0100, 32'h11BB_33DD, 1'b1);
    idle_cycles(4);

`ifdef MEM_RESP_PERF_EN
    // Fetch blocked by three consecutive stores
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("perf_rst_inst", perf_inst_stall, 0);
    chk("perf_rst_data", perf_data_stall, 0);
    @(posedge clk); #1;
    PC = 32'h0000_0040; Inst_Req_Valid = 1'b1;
    do_store(32'h0000_0200, 32'h0000_0001, 4'hF);
    do_store(32'h0000_0204, 32'h0000_0002, 4'hF);
    do_store(32'h0000_0208, 32'h0000_0003, 4'hF);
    @(negedge clk);
    chk("perf_fetch_ready", Inst_Req_Ready, 1);
    x.dat = 32'h0050_0093; x.due = cyc + INST_LAT; iq.push_back(x);
    @(posedge clk); #1;
    Inst_Req_Valid = 1'b0;
    @(negedge clk);
    chk("perf_inst_stall", perf_inst_stall, 3);
    chk("perf_data_stall", perf_data_stall, 0);
    idle_cycles(3);
`endif

    // Drain: every expected response must have arrived
    for (int i = 0; i < 50 && (iq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("inst_queue_empty", iq.size(), 0);
    chk("data_queue_empty", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the custom CPU's instruction and data channels: it accepts instruction-fetch and load/store requests, serves them from one single-port word array, and returns read data over the valid/ready response channels after a configurable latency. It sits on the far side of the CPU's PC/Instruction and Address/Read_data ports and is the standard simulation and FPGA memory behind the pipelined core.

## Interface
- ADDR_WIDTH, 12: word-index bits of the array (2^ADDR_WIDTH words).
- INST_LAT, 1: cycles from instruction-request acceptance to Inst_Valid; legal range 1..15.
- DATA_LAT, 2: cycles from read-request acceptance to Read_data_Valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- PC  in  32  instruction fetch address
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  fetch request accepted
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ready  in  1  CPU accepts Instruction
- Address  in  32  data byte address
- MemWrite  in  1  store request
- Write_data  in  32  store data
- Write_strb  in  4  store byte enables
- MemRead  in  1  load request
- Mem_Req_Ready  out  1  data request accepted
- Read_data  out  32  load word
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ready  in  1  CPU accepts Read_data

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] and upper bits ignored (aliasing wrap-around).
- Each channel runs its own FSM: IDLE -> WAIT -> RESP -> IDLE, with one outstanding request per channel.
- IDLE: a request is accepted on a cycle where both valid and ready are high. The array is read on the accept edge into the channel's holding register. The FSM goes to WAIT with counter = LAT-1, or directly to RESP if LAT=1.
- WAIT: the counter decrements each cycle; at 0 the FSM enters RESP.
- RESP: valid held high and data held stable until ready, then IDLE.
- Stores: accepted only when the data FSM is in IDLE. Bytes are written per Write_strb on the accept edge. No response is issued, and the data FSM stays in IDLE.
- MemRead and MemWrite both high: treated as a store; the read is ignored.
- Arbitration: Mem_Req_Ready = data FSM in IDLE. Inst_Req_Ready = inst FSM in IDLE AND NOT (MemRead|MemWrite). The data channel wins a same-cycle conflict.
- Read-after-write: a read accepted the cycle after a store returns the new bytes.
- Reset (rst low at an edge): both FSMs go to IDLE and counters clear. Inst_Valid, Read_data_Valid, Instruction and Read_data go to 0. Array contents are retained; an in-flight response is dropped.
- Outputs during reset (rst low): Inst_Req_Ready=0 and Mem_Req_Ready=0.

## Timing
- With LAT=1, a request accepted at edge T has valid high during cycle T+1. In general valid rises LAT cycles after the accept edge.
- Back-to-back throughput: at minimum LAT+1 cycles per request per channel. No same-cycle RESP-to-accept turnaround.
- Store: a single accept cycle; Mem_Req_Ready is high again the next cycle.
- Ready outputs are combinational from FSM state and request inputs. Valid and data outputs are registered.

## Configuration
- MEM_RESP_PERF_EN defined: adds outputs perf_inst_stall (32 bit) and perf_data_stall (32 bit).
  - perf_inst_stall counts cycles with Inst_Req_Valid high and Inst_Req_Ready low.
  - perf_data_stall counts cycles with (MemRead|MemWrite) high and Mem_Req_Ready low.
  - Both are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package mem_resp_pkg holds:
  - the channel state enum (IDLE, WAIT, RESP);
  - LAT_MIN=1 and LAT_MAX=15;
  - the 4-bit latency counter width.
- Sub-module resp_channel contains the FSM, latency counter, holding register and valid/ready logic, parameterised by LAT. It is instantiated once for instructions and once for data.
- The top level holds the array, the byte-strobe write, arbitration and the optional perf counters.

## Test plan
- Preload word 0x10 = 0x00500093. Fetch PC=0x40 with INST_LAT=1 -> Inst_Valid high one cycle after accept, Instruction=0x00500093.
- Store Address=0x100, Write_data=0xAABBCCDD, Write_strb=0b0101, over old 0x11223344; then load 0x100 -> Read_data=0x11BB33DD, valid DATA_LAT=2 cycles after accept.
- Fetch and load requested in the same cycle -> Mem_Req_Ready=1 and Inst_Req_Ready=0; the fetch is accepted the following cycle.
- Read_data_Ready held low 5 cycles in RESP -> Read_data_Valid stays high with a stable value; a new MemRead is not accepted until the handshake completes.
- rst pulsed low during data WAIT -> Read_data_Valid stays 0 and both readys are high after release; a later load returns the pre-reset array contents.
- With MEM_RESP_PERF_EN, hold a fetch blocked by 3 consecutive stores -> perf_inst_stall=3.
